// File: rtl/data_sram_axi_bridge_pkg.sv
// rtl/data_sram_axi_bridge_pkg.sv - shared types and AXI constants for the data-port bridge
package data_sram_axi_bridge_pkg;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_RD_ADDR,
        ST_RD_DATA,
        ST_WR,
        ST_WR_RESP,
        ST_DONE
    } state_e;

    localparam logic [3:0] AXI_ID         = 4'd1;
    localparam logic [7:0] AXI_LEN_SINGLE = 8'd0;
    localparam logic [1:0] AXI_BURST_INCR = 2'b01;

    // SRAM size code 0/1/2 maps directly onto AXI AxSIZE 1/2/4 bytes
    function automatic logic [2:0] axi_size(input logic [1:0] size);
        return {1'b0, size};
    endfunction

endpackage

// File: rtl/data_sram_axi_bridge_if.sv
// rtl/data_sram_axi_bridge_if.sv - AXI3 single-beat channel bundle between bridge and interconnect
interface data_sram_axi_bridge_if;

    logic [3:0]  arid;
    logic [31:0] araddr;
    logic [7:0]  arlen;
    logic [2:0]  arsize;
    logic [1:0]  arburst;
    logic        arvalid;
    logic        arready;

    logic [3:0]  rid;
    logic [31:0] rdata;
    logic [1:0]  rresp;
    logic        rlast;
    logic        rvalid;
    logic        rready;

    logic [3:0]  awid;
    logic [31:0] awaddr;
    logic [7:0]  awlen;
    logic [2:0]  awsize;
    logic [1:0]  awburst;
    logic        awvalid;
    logic        awready;

    logic [3:0]  wid;
    logic [31:0] wdata;
    logic [3:0]  wstrb;
    logic        wlast;
    logic        wvalid;
    logic        wready;

    logic [3:0]  bid;
    logic [1:0]  bresp;
    logic        bvalid;
    logic        bready;

    modport master (
        output arid, araddr, arlen, arsize, arburst, arvalid,
        input  arready,
        input  rid, rdata, rresp, rlast, rvalid,
        output rready,
        output awid, awaddr, awlen, awsize, awburst, awvalid,
        input  awready,
        output wid, wdata, wstrb, wlast, wvalid,
        input  wready,
        input  bid, bresp, bvalid,
        output bready
    );

    modport slave (
        input  arid, araddr, arlen, arsize, arburst, arvalid,
        output arready,
        output rid, rdata, rresp, rlast, rvalid,
        input  rready,
        input  awid, awaddr, awlen, awsize, awburst, awvalid,
        output awready,
        input  wid, wdata, wstrb, wlast, wvalid,
        output wready,
        output bid, bresp, bvalid,
        input  bready
    );

endinterface

// File: rtl/data_sram_axi_bridge.sv
// rtl/data_sram_axi_bridge.sv - data-side SRAM-like request port to single-beat AXI3, one transaction in flight
module data_sram_axi_bridge
    import data_sram_axi_bridge_pkg::*;
(
    input  logic        clk,
    input  logic        resetn,
    input  logic        data_sram_req,
    input  logic        data_sram_wr,
    input  logic [1:0]  data_sram_size,
    input  logic [3:0]  data_sram_wstrb,
    input  logic [31:0] data_sram_addr,
    input  logic [31:0] data_sram_wdata,
    output logic        data_sram_addr_ok,
    output logic        data_sram_data_ok,
    output logic [31:0] data_sram_rdata,
    data_sram_axi_bridge_if.master axi
);

    state_e      state_q, state_d;
    logic [31:0] addr_q, addr_d;
    logic [1:0]  size_q, size_d;
    logic [3:0]  wstrb_q, wstrb_d;
    logic [31:0] wdata_q, wdata_d;
    logic [31:0] rdata_q, rdata_d;
    logic        aw_done_q, aw_done_d;
    logic        w_done_q, w_done_d;

    // Payload comes straight from the request latches, so it is stable while any valid waits
    assign axi.arid    = AXI_ID;
    assign axi.araddr  = addr_q;
    assign axi.arlen   = AXI_LEN_SINGLE;
    assign axi.arsize  = axi_size(size_q);
    assign axi.arburst = AXI_BURST_INCR;
    assign axi.awid    = AXI_ID;
    assign axi.awaddr  = addr_q;
    assign axi.awlen   = AXI_LEN_SINGLE;
    assign axi.awsize  = axi_size(size_q);
    assign axi.awburst = AXI_BURST_INCR;
    assign axi.wid     = AXI_ID;
    assign axi.wdata   = wdata_q;
    assign axi.wstrb   = wstrb_q;
    assign axi.wlast   = 1'b1;

    assign data_sram_rdata = rdata_q;

    logic unused_axi;
    assign unused_axi = ^{axi.rid, axi.rresp, axi.rlast, axi.bid, axi.bresp};

    always_ff @(posedge clk) begin
        if (!resetn) begin
            state_q   <= ST_IDLE;
            addr_q    <= '0;
            size_q    <= '0;
            wstrb_q   <= '0;
            wdata_q   <= '0;
            rdata_q   <= '0;
            aw_done_q <= 1'b0;
            w_done_q  <= 1'b0;
        end else begin
            state_q   <= state_d;
            addr_q    <= addr_d;
            size_q    <= size_d;
            wstrb_q   <= wstrb_d;
            wdata_q   <= wdata_d;
            rdata_q   <= rdata_d;
            aw_done_q <= aw_done_d;
            w_done_q  <= w_done_d;
        end
    end

    always_comb begin
        state_d           = state_q;
        addr_d            = addr_q;
        size_d            = size_q;
        wstrb_d           = wstrb_q;
        wdata_d           = wdata_q;
        rdata_d           = rdata_q;
        aw_done_d         = aw_done_q;
        w_done_d          = w_done_q;
        data_sram_addr_ok = 1'b0;
        data_sram_data_ok = 1'b0;
        axi.arvalid       = 1'b0;
        axi.rready        = 1'b0;
        axi.awvalid       = 1'b0;
        axi.wvalid        = 1'b0;
        axi.bready        = 1'b0;

        case (state_q)
            ST_IDLE: begin
                data_sram_addr_ok = data_sram_req && resetn;
                if (data_sram_req) begin
                    addr_d  = data_sram_addr;
                    size_d  = data_sram_size;
                    wstrb_d = data_sram_wstrb;
                    wdata_d = data_sram_wdata;
                    state_d = data_sram_wr ? ST_WR : ST_RD_ADDR;
                end
            end
            ST_RD_ADDR: begin
                axi.arvalid = 1'b1;
                if (axi.arready) begin
                    state_d = ST_RD_DATA;
                end
            end
            ST_RD_DATA: begin
                axi.rready = 1'b1;
                if (axi.rvalid) begin
                    rdata_d = axi.rdata;
                    state_d = ST_DONE;
                end
            end
            ST_WR: begin
                // AW and W complete independently; each valid drops once its own beat is taken
                axi.awvalid = ~aw_done_q;
                axi.wvalid  = ~w_done_q;
                aw_done_d   = aw_done_q | (~aw_done_q & axi.awready);
                w_done_d    = w_done_q | (~w_done_q & axi.wready);
                if (aw_done_d && w_done_d) begin
                    aw_done_d = 1'b0;
                    w_done_d  = 1'b0;
                    state_d   = ST_WR_RESP;
                end
            end
            ST_WR_RESP: begin
                axi.bready = 1'b1;
                if (axi.bvalid) begin
                    state_d = ST_DONE;
                end
            end
            ST_DONE: begin
                data_sram_data_ok = 1'b1;
                state_d           = ST_IDLE;
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

endmodule

// File: tb/tb_data_sram_axi_bridge.sv
// tb/tb_data_sram_axi_bridge.sv - directed and randomized checks of the data-port AXI bridge
module tb_data_sram_axi_bridge;

    logic        clk = 1'b0;
    logic        resetn = 1'b0;
    logic        sreq, swr;
    logic [1:0]  ssize;
    logic [3:0]  sstrb;
    logic [31:0] saddr, swdata;
    logic        saok, sdok;
    logic [31:0] srdata;

    always #5 clk = ~clk;

    data_sram_axi_bridge_if axi();

    data_sram_axi_bridge dut (
        .clk               (clk),
        .resetn            (resetn),
        .data_sram_req     (sreq),
        .data_sram_wr      (swr),
        .data_sram_size    (ssize),
        .data_sram_wstrb   (sstrb),
        .data_sram_addr    (saddr),
        .data_sram_wdata   (swdata),
        .data_sram_addr_ok (saok),
        .data_sram_data_ok (sdok),
        .data_sram_rdata   (srdata),
        .axi               (axi)
    );

    // d1: AR or AW stall cycles, d2: R delay after AR (read) or W stall (write), d3: B delay
    typedef struct {
        bit        wr;
        bit [1:0]  size;
        bit [31:0] addr;
        bit [31:0] wdata;
        bit [3:0]  wstrb;
        bit [31:0] rd;
        int        d1;
        int        d2;
        int        d3;
    } txn_t;

    txn_t q[$];
    int   checks = 0;
    int   errors = 0;
    int   ar_cnt, aw_cnt, w_cnt, r_cnt, b_cnt;
    bit   r_pend, b_pend, aw_seen, w_seen, rready_seen;
    int   n_ar, n_aw, n_w;

    function automatic txn_t mk(bit wr, bit [1:0] sz, bit [31:0] a, bit [31:0] wd,
                                bit [3:0] st, bit [31:0] rd, int d1, int d2, int d3);
        txn_t t;
        t.wr = wr; t.size = sz; t.addr = a; t.wdata = wd; t.wstrb = st; t.rd = rd;
        t.d1 = d1; t.d2 = d2; t.d3 = d3;
        return t;
    endfunction

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed 0x%08h expected 0x%08h", tag, obs, exp);
        end
    endtask

    task automatic slave_clear();
        ar_cnt = 0; aw_cnt = 0; w_cnt = 0; r_cnt = 0; b_cnt = 0;
        r_pend = 0; b_pend = 0; aw_seen = 0; w_seen = 0;
    endtask

    task automatic drive();
        axi.rid = 4'd1; axi.rresp = 2'b00; axi.rlast = 1'b1; axi.bid = 4'd1; axi.bresp = 2'b00;
        if (q.size() == 0) begin
            axi.arready = 0; axi.rvalid = 0; axi.rdata = 0;
            axi.awready = 0; axi.wready = 0; axi.bvalid = 0;
        end else begin
            axi.arready = axi.arvalid && (ar_cnt >= q[0].d1);
            axi.rvalid  = r_pend && (r_cnt >= q[0].d2);
            axi.rdata   = axi.rvalid ? q[0].rd : 32'h0;
            axi.awready = axi.awvalid && (aw_cnt >= q[0].d1);
            axi.wready  = axi.wvalid && (w_cnt >= q[0].d2);
            axi.bvalid  = b_pend && (b_cnt >= q[0].d3);
        end
    endtask

    task automatic sample();
        txn_t t;
        if (q.size() == 0) return;
        t = q[0];
        if (axi.rready) rready_seen = 1;
        if (axi.rvalid && axi.rready) r_pend = 0;
        else if (r_pend) r_cnt++;
        if (axi.bvalid && axi.bready) begin b_pend = 0; aw_seen = 0; w_seen = 0; end
        else if (b_pend) b_cnt++;
        if (axi.arvalid) begin
            chk("araddr", axi.araddr, t.addr);
            chk("arsize", {29'd0, axi.arsize}, {29'd0, 1'b0, t.size});
            chk("arlen", {24'd0, axi.arlen}, 32'd0);
            chk("arburst_arid", {26'd0, axi.arburst, axi.arid}, {26'd0, 2'b01, 4'd1});
            if (axi.arready) begin n_ar++; r_pend = 1; r_cnt = 0; end
            else ar_cnt++;
        end
        if (axi.awvalid) begin
            chk("awaddr", axi.awaddr, t.addr);
            chk("awsize", {29'd0, axi.awsize}, {29'd0, 1'b0, t.size});
            chk("awlen_awburst_awid", {18'd0, axi.awlen, axi.awburst, axi.awid}, {18'd0, 8'd0, 2'b01, 4'd1});
            if (axi.awready) begin n_aw++; aw_seen = 1; end
            else aw_cnt++;
        end
        if (axi.wvalid) begin
            chk("wdata", axi.wdata, t.wdata);
            chk("wstrb_wlast_wid", {23'd0, axi.wstrb, axi.wlast, axi.wid}, {23'd0, t.wstrb, 1'b1, 4'd1});
            if (axi.wready) begin n_w++; w_seen = 1; end
            else w_cnt++;
        end
        if (aw_seen && w_seen && !b_pend) begin b_pend = 1; b_cnt = 0; end
    endtask

    task automatic one_cycle();
        @(posedge clk); #1;
        if (q.size() > 0) begin
            sreq = 1; swr = q[0].wr; ssize = q[0].size; saddr = q[0].addr;
            swdata = q[0].wdata; sstrb = q[0].wstrb;
        end else begin
            sreq = 0;
        end
        drive();
        @(negedge clk);
        sample();
    endtask

    // Requests are presented back to back with req held high until the queue drains
    task automatic run_seq(input string tag);
        int   cyc = 0;
        int   last_ok = -1;
        int   acc = 0;
        int   exp_ar = 0;
        int   exp_wr = 0;
        int   exp_lat;
        txn_t t;
        n_ar = 0; n_aw = 0; n_w = 0;
        slave_clear();
        foreach (q[i]) if (q[i].wr) exp_wr++; else exp_ar++;
        while (q.size() > 0 && cyc < 400) begin
            one_cycle();
            if (saok) begin
                chk({tag, " addr_ok_cycle"}, cyc, last_ok + 1);
                acc = cyc;
            end
            if (sdok) begin
                t = q[0];
                exp_lat = t.wr ? 3 + ((t.d1 > t.d2) ? t.d1 : t.d2) + t.d3 : 3 + t.d1 + t.d2;
                chk({tag, " latency"}, cyc - acc, exp_lat);
                if (!t.wr) chk({tag, " rdata"}, srdata, t.rd);
                last_ok = cyc;
                void'(q.pop_front());
                slave_clear();
            end
            cyc++;
        end
        chk({tag, " timeout_left"}, q.size(), 0);
        q.delete();
        one_cycle();
        chk({tag, " idle_after"}, {30'd0, saok, sdok}, 32'd0);
        chk({tag, " ar_beats"}, n_ar, exp_ar);
        chk({tag, " aw_beats"}, n_aw, exp_wr);
        chk({tag, " w_beats"}, n_w, exp_wr);
    endtask

    initial begin
        sreq = 1; swr = 0; ssize = 0; sstrb = 0; saddr = 0; swdata = 0;
        slave_clear();
        drive();
        resetn = 0;
        repeat (2) @(posedge clk);
        @(negedge clk);
        chk("reset outputs", {25'd0, saok, sdok, axi.arvalid, axi.rready, axi.awvalid, axi.wvalid, axi.bready}, 32'd0);
        chk("reset rdata", srdata, 32'd0);
        sreq = 0;
        resetn = 1;

        q.push_back(mk(0, 2'd2, 32'h1C00_0010, 32'h0, 4'h0, 32'hDEAD_BEEF, 0, 0, 0));
        run_seq("rd_word");

        q.push_back(mk(1, 2'd0, 32'h1C00_0003, 32'h5A5A_5A5A, 4'b1000, 32'h0, 0, 0, 0));
        run_seq("wr_byte");

        q.push_back(mk(1, 2'd2, 32'h1C00_0020, 32'hCAFE_F00D, 4'hF, 32'h0, 3, 0, 0));
        run_seq("wr_w_first");

        q.push_back(mk(1, 2'd1, 32'h1C00_0042, 32'h1234_1234, 4'b1100, 32'h0, 0, 2, 1));
        run_seq("wr_aw_first");

        q.push_back(mk(0, 2'd1, 32'h1C00_0032, 32'h0, 4'h0, 32'h0BAD_F00D, 4, 2, 0));
        run_seq("rd_slow");

        q.push_back(mk(1, 2'd2, 32'h1C00_0100, 32'h1111_2222, 4'hF, 32'h0, 0, 0, 0));
        q.push_back(mk(0, 2'd2, 32'h1C00_0104, 32'h0, 4'h0, 32'h3333_4444, 0, 0, 0));
        run_seq("b2b");

        q.push_back(mk(0, 2'd2, 32'h1C00_0200, 32'h0, 4'h0, 32'h5555_6666, 0, 20, 0));
        slave_clear();
        rready_seen = 0;
        for (int i = 0; i < 10 && !rready_seen; i++) one_cycle();
        chk("rst reached rd_data", {31'd0, rready_seen}, 32'd1);
        resetn = 0;
        q.delete();
        slave_clear();
        one_cycle();
        chk("rst outputs", {25'd0, saok, sdok, axi.arvalid, axi.rready, axi.awvalid, axi.wvalid, axi.bready}, 32'd0);
        chk("rst rdata", srdata, 32'd0);
        resetn = 1;
        q.push_back(mk(0, 2'd2, 32'h1C00_0204, 32'h0, 4'h0, 32'h7777_8888, 1, 1, 0));
        run_seq("after_rst");

        for (int g = 0; g < 4; g++) begin
            for (int k = 0; k < 6; k++) begin
                q.push_back(mk($urandom_range(0, 1), 2'($urandom_range(0, 2)), $urandom, $urandom,
                               4'($urandom_range(0, 15)), $urandom,
                               $urandom_range(0, 3), $urandom_range(0, 3), $urandom_range(0, 3)));
            end
            run_seq($sformatf("rand%0d", g));
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/data_sram_axi_bridge.md
# data_sram_axi_bridge

Responder for the data-side SRAM-like request interface that the execute stage drives (req/wr/size/wstrb/addr/wdata, answered with addr_ok, data_ok and rdata). It converts each accepted request into a single-beat AXI3 read or write transaction and returns the completion to the pipeline. Sits between the CPU core's data port and the AXI interconnect. One outstanding transaction at a time.

## Interface
- AXI_ID, 4'd1: ID driven on arid/awid/wid (data port).
- clk  in  1  clock, all state on rising edge.
- resetn  in  1  synchronous, active-low reset.
- data_sram_req  in  1  request valid from EX.
- data_sram_wr  in  1  1 = write, 0 = read.
- data_sram_size  in  2  0 = byte, 1 = half, 2 = word.
- data_sram_wstrb  in  4  byte strobes (writes only).
- data_sram_addr  in  32  physical address.
- data_sram_wdata  in  32  write data, already lane-replicated.
- data_sram_addr_ok  out  1  request accepted this cycle.
- data_sram_data_ok  out  1  one-cycle completion pulse.
- data_sram_rdata  out  32  read data, valid with data_ok on reads.
- arid/araddr/arlen/arsize/arburst/arvalid  out  4/32/8/3/2/1  AXI read address.
- arready  in  1.
- rid/rdata/rresp/rlast/rvalid  in  4/32/2/1/1; rready  out  1.
- awid/awaddr/awlen/awsize/awburst/awvalid  out  4/32/8/3/2/1; awready  in  1.
- wid/wdata/wstrb/wlast/wvalid  out  4/32/4/1/1; wready  in  1.
- bid/bresp/bvalid  in  4/2/1; bready  out  1.

## Operation
- States: IDLE, RD_ADDR, RD_DATA, WR, WR_RESP, DONE.
- IDLE: addr_ok = req (combinational); on req, latch addr, size, wstrb, wdata, wr; go RD_ADDR if wr=0, else WR.
- RD_ADDR: arvalid=1, araddr=latched addr, arsize={1'b0,size}; on arready -> RD_DATA.
- RD_DATA: rready=1; on rvalid capture rdata into rdata register -> DONE.
- WR: awvalid = ~aw_done, wvalid = ~w_done; flags aw_done/w_done set on respective handshake, AW and W complete in either order or same cycle; when both done (including flags set this cycle) -> WR_RESP, flags cleared.
- WR_RESP: bready=1; on bvalid -> DONE.
- DONE: data_ok=1 for exactly one cycle, addr_ok=0; -> IDLE.
- Fixed fields: arlen=awlen=0, arburst=awburst=2'b01, wlast=1, all IDs = AXI_ID. Address passed unmodified; sub-word writes rely on wstrb.
- rresp/bresp/rid/bid/rlast ignored; no error reporting.
- data_sram_rdata holds last captured read value until the next read capture; undefined for writes.
- addr_ok never asserted outside IDLE; requests presented in other states are held by the requester and not accepted.

## Timing
- Reset: state IDLE, all valids/readies 0, addr_ok follows req only after reset released, data_ok 0, rdata 0, flags 0.
- Read, zero-wait slave: req+addr_ok cycle 0, arvalid cycle 1, rready cycle 2 with rvalid, data_ok cycle 3. Minimum 3 cycles req->data_ok.
- Write, zero-wait: addr_ok 0, awvalid+wvalid 1, bready 2 with bvalid, data_ok 3.
- Next addr_ok earliest the cycle after data_ok (issue rate 1 per 4 cycles best case).
- arvalid/awvalid/wvalid held with stable payload until handshake (AXI rule).
- Reset mid-transaction: returns to IDLE next edge, drops all valids; outstanding AXI beats are not tracked (system-wide reset only).

## Structure
- Shared package: state encoding, AXI burst/size constants, data-port ID, fixed-length constants.
- Single flat module; no sub-module required.

## Test plan
- Word read, addr 0x1C00_0010, slave arready/rvalid immediate, rdata 0xDEADBEEF -> data_ok at cycle 3 with rdata 0xDEADBEEF, arsize 3'b010, arlen 0.
- Byte write addr 0x1C00_0003, wstrb 4'b1000, wdata 0x5A5A5A5A -> awaddr unchanged, wstrb 4'b1000, awsize 0, wlast 1, data_ok after bvalid.
- Write with wready 3 cycles before awready -> wvalid drops after W handshake, awvalid held, exactly one AW and one W beat, single data_ok.
- Read with arready delayed 4 cycles and rvalid delayed 2 -> araddr stable throughout, data_ok exactly one cycle, no addr_ok until after DONE.
- Back-to-back req held high across a write then a read -> second addr_ok only the cycle after first data_ok; two data_ok pulses total.
- resetn low during RD_DATA -> next cycle all valids/readies 0, data_ok 0, state IDLE, fresh request completes normally.
